fetch_decode_stage: RTL and testbench
=====================================

Name: fetch_decode_stage

Overview:
- Parametrised instruction fetch/decode front end: PC register, writable instruction memory, registered IF/ID stage and MIPS-format field decode.
- Successor to the fixed 4-bit PC / fixed-ROM / combinational-decode chain. Adds configurable address width, stall, branch/jump redirect with squash, a program-load port and a retired-fetch counter.
- Feeds the register-file / execute stages.

Parameters:
- ADDR_W, 4, PC and instruction-memory address width (word addressed); memory depth = 2**ADDR_W.
- DATA_W, 32, instruction width; must be 32 for MIPS field decode.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of fetch counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global run; when 0, PC and IF/ID hold.
- stall  in  1  hold PC and IF/ID (downstream hazard).
- redirect  in  1  load PC from redirect_pc, squash the in-flight fetch.
- redirect_pc  in  ADDR_W  branch/jump target.
- prog_we  in  1  instruction-memory write enable.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  DATA_W  write data.
- pc  out  ADDR_W  current fetch PC.
- id_valid  out  1  IF/ID contents valid.
- id_pc  out  ADDR_W  PC of the instruction in IF/ID.
- instruction  out  DATA_W  registered instruction.
- opcode  out  6  instr[31:26].
- rs, rt, rd, shamt  out  5 each  instr[25:21], [20:16], [15:11], [10:6].
- funct  out  6  instr[5:0].
- immediate  out  16  instr[15:0].
- imm_sext  out  32  immediate sign-extended.
- jump_target  out  26  instr[25:0].
- isRtype, isItype, isJtype  out  1 each  format flags.
- fetch_count  out  CNT_W  instructions accepted into IF/ID.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC.
  - id_valid = 0, id_pc = 0, instruction = 0, fetch_count = 0.
  - All decode outputs = 0.
  - Memory contents are not cleared.
- Memory:
  - 2**ADDR_W x DATA_W.
  - Combinational read at pc.
  - Synchronous write on the rising edge when prog_we = 1.
  - Write is independent of enable and stall.
  - Same-cycle write to the address being fetched: the fetch captures the old data (read-before-write).
- Per rising edge, evaluated in priority order:
  1. enable = 0: pc, IF/ID and fetch_count hold.
  2. redirect = 1 (wins over stall): pc <= redirect_pc; id_valid <= 0; instruction and fields hold; fetch_count holds.
  3. stall = 1: pc and IF/ID hold, id_valid unchanged; fetch_count holds.
  4. Otherwise: instruction <= mem[pc]; id_pc <= pc; id_valid <= 1; pc <= pc + 1; fetch_count <= fetch_count + 1.
- Latency: the word at PC p appears on instruction/fields one cycle after the edge at which pc = p was accepted.
- Wrap-around:
  - pc = 2**ADDR_W-1 increments to 0; no flag.
  - fetch_count wraps modulo 2**CNT_W.
- Decode is combinational from the registered instruction:
  - isJtype = (opcode == 6'h02 || opcode == 6'h03).
  - isRtype = (opcode == 0).
  - isItype = !isRtype && !isJtype.
  - imm_sext = {{16{instruction[15]}}, instruction[15:0]}.
- Format flags are forced to 0 while id_valid = 0 (field outputs still reflect the held instruction).
- Reset asserted mid-stream discards the in-flight instruction. Fetch restarts at RESET_PC on the first enabled edge after release.

Test Plan:
- Preload mem[0..3] = 00221820, 8C430004, 08000002, 2062FFFF; release reset with enable=1 -> cycle 1: id_pc=0, rd=3, isRtype=1; cycle 2: rt=3, rs=2, isItype=1; cycle 3: isJtype=1, jump_target=2; cycle 4: imm_sext=FFFFFFFF; fetch_count=4.
- Assert stall for 3 cycles at pc=2 -> pc stays 2, instruction/id_valid unchanged, fetch_count frozen; release -> pc=3 next edge.
- Redirect to 5 while stall=1 at pc=2 -> next edge pc=5, id_valid=0, flags 0; following edge id_pc=5, id_valid=1.
- ADDR_W=4, run from 14 -> pc sequence 14, 15, 0, 1; id_pc follows one cycle later.
- prog_we to mem[pc] in the same cycle the fetch accepts it -> IF/ID gets the old word; the next fetch of that address gets the new word.
- Assert reset mid-run (not clock aligned) -> outputs zero immediately, pc=RESET_PC; enable=0 after release -> pc holds RESET_PC.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// Fetch/decode front end: PC, writable instruction memory, IF/ID register and MIPS field decode.
// One cycle from PC acceptance to instruction/fields; stall or enable=0 holds PC and IF/ID, redirect squashes.
module fetch_decode_stage #(
   parameter int                  ADDR_W   = 4,
   parameter int                  DATA_W   = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = '0,
   parameter int                  CNT_W    = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [ADDR_W-1:0] pc,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [DATA_W-1:0] instruction,
   output logic [5:0]        opcode,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [5:0]        funct,
   output logic [15:0]       immediate,
   output logic [31:0]       imm_sext,
   output logic [25:0]       jump_target,
   output logic              isRtype,
   output logic              isItype,
   output logic              isJtype,
   output logic [CNT_W-1:0]  fetch_count
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] id_pc_q, id_pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Memory is never cleared; nonblocking write gives read-before-write for a same-edge fetch.
   always_ff @(posedge clock) begin
      if (prog_we) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

   always_comb begin
      pc_d    = pc_q;
      valid_d = valid_q;
      id_pc_d = id_pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      if (enable) begin
         if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
         end else if (!stall) begin
            instr_d = mem_q[pc_q];
            id_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         id_pc_q <= '0;
         instr_q <= '0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
         id_pc_q <= id_pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
      end
   end

   logic op_r, op_j;

   assign op_r = (instr_q[31:26] == 6'h00);
   assign op_j = (instr_q[31:26] == 6'h02) || (instr_q[31:26] == 6'h03);

   assign pc          = pc_q;
   assign id_valid    = valid_q;
   assign id_pc       = id_pc_q;
   assign instruction = instr_q;
   assign fetch_count = cnt_q;

   assign opcode      = instr_q[31:26];
   assign rs          = instr_q[25:21];
   assign rt          = instr_q[20:16];
   assign rd          = instr_q[15:11];
   assign shamt       = instr_q[10:6];
   assign funct       = instr_q[5:0];
   assign immediate   = instr_q[15:0];
   assign imm_sext    = {{16{instr_q[15]}}, instr_q[15:0]};
   assign jump_target = instr_q[25:0];

   // Flags are qualified by id_valid so a squashed slot never looks like a real instruction.
   assign isRtype = valid_q && op_r;
   assign isJtype = valid_q && op_j;
   assign isItype = valid_q && !op_r && !op_j;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Self-checking bench for fetch_decode_stage against a behavioural model.
module tb_fetch_decode_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable, stall, redirect, prog_we;
   logic [3:0]  redirect_pc, prog_addr;
   logic [31:0] prog_data;
   logic [3:0]  pc, id_pc;
   logic        id_valid;
   logic [31:0] instruction, imm_sext;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] immediate;
   logic [25:0] jump_target;
   logic        isRtype, isItype, isJtype;
   logic [15:0] fetch_count;

   fetch_decode_stage #(.ADDR_W(4), .DATA_W(32), .RESET_PC(4'd0), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .enable(enable), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .pc(pc), .id_valid(id_valid), .id_pc(id_pc), .instruction(instruction),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .immediate(immediate), .imm_sext(imm_sext), .jump_target(jump_target),
      .isRtype(isRtype), .isItype(isItype), .isJtype(isJtype),
      .fetch_count(fetch_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model state, plain integers and an array.
   int unsigned m_mem [16];
   int unsigned m_pc, m_idpc, m_instr, m_cnt;
   bit          m_valid;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_idpc = 0; m_instr = 0; m_cnt = 0; m_valid = 0;
   endtask

   task automatic check_all(input string tag);
      int unsigned op, imm;
      bit r, j;
      op  = (m_instr >> 26) & 63;
      imm = m_instr & 16'hFFFF;
      r   = m_valid && (op == 0);
      j   = m_valid && (op == 2 || op == 3);
      check({tag, ".pc"},       pc,          m_pc);
      check({tag, ".valid"},    id_valid,    m_valid);
      check({tag, ".id_pc"},    id_pc,       m_idpc);
      check({tag, ".instr"},    instruction, m_instr);
      check({tag, ".opcode"},   opcode,      op);
      check({tag, ".rs"},       rs,          (m_instr >> 21) & 31);
      check({tag, ".rt"},       rt,          (m_instr >> 16) & 31);
      check({tag, ".rd"},       rd,          (m_instr >> 11) & 31);
      check({tag, ".shamt"},    shamt,       (m_instr >> 6) & 31);
      check({tag, ".funct"},    funct,       m_instr & 63);
      check({tag, ".imm"},      immediate,   imm);
      check({tag, ".sext"},     imm_sext,    (imm >= 32768) ? (imm + 32'hFFFF0000) : imm);
      check({tag, ".jt"},       jump_target, m_instr & 32'h03FFFFFF);
      check({tag, ".isR"},      isRtype,     r);
      check({tag, ".isJ"},      isJtype,     j);
      check({tag, ".isI"},      isItype,     m_valid && !r && !j);
      check({tag, ".cnt"},      fetch_count, m_cnt);
   endtask

   // One clock: drive inputs, update the model at the edge, check 1 time unit later.
   task automatic cycle(input string tag, input bit en, input bit st, input bit rdr,
                        input int unsigned rpc, input bit we, input int unsigned wa,
                        input int unsigned wd);
      int unsigned old;
      enable = en; stall = st; redirect = rdr; redirect_pc = 4'(rpc);
      prog_we = we; prog_addr = 4'(wa); prog_data = wd;
      @(posedge clock);
      old = m_mem[m_pc];
      if (we) m_mem[wa] = wd;
      if (en) begin
         if (rdr) begin
            m_pc = rpc; m_valid = 0;
         end else if (!st) begin
            m_instr = old; m_idpc = m_pc; m_valid = 1;
            m_pc = (m_pc + 1) % 16; m_cnt = (m_cnt + 1) % 65536;
         end
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      int unsigned prog [4];
      int unsigned wa_old;
      prog[0] = 32'h00221820; prog[1] = 32'h8C430004;
      prog[2] = 32'h08000002; prog[3] = 32'h2062FFFF;

      reset = 1'b1; enable = 0; stall = 0; redirect = 0; redirect_pc = 0;
      prog_we = 0; prog_addr = 0; prog_data = 0;
      model_reset();
      #2;
      check_all("reset");

      // Preload whole memory while held in reset.
      for (int a = 0; a < 16; a++) begin
         prog_we = 1; prog_addr = 4'(a);
         prog_data = (a < 4) ? prog[a] : $urandom;
         @(posedge clock);
         m_mem[a] = prog_data;
         #1;
      end
      prog_we = 0;
      @(negedge clock);
      reset = 1'b0;

      cycle("c1", 1, 0, 0, 0, 0, 0, 0);
      check("c1.id_pc", id_pc, 0);
      check("c1.rd", rd, 3);
      check("c1.isR", isRtype, 1);
      cycle("c2", 1, 0, 0, 0, 0, 0, 0);
      check("c2.rt", rt, 3);
      check("c2.rs", rs, 2);
      check("c2.isI", isItype, 1);

      for (int i = 0; i < 3; i++) begin
         cycle("stall", 1, 1, 0, 0, 0, 0, 0);
         check("stall.pc", pc, 2);
         check("stall.cnt", fetch_count, 2);
      end
      cycle("c3", 1, 0, 0, 0, 0, 0, 0);
      check("c3.pc", pc, 3);
      check("c3.isJ", isJtype, 1);
      check("c3.jt", jump_target, 2);
      cycle("c4", 1, 0, 0, 0, 0, 0, 0);
      check("c4.sext", imm_sext, 32'hFFFFFFFF);
      check("c4.cnt", fetch_count, 4);

      // Redirect wins over stall.
      cycle("rd2", 1, 0, 1, 2, 0, 0, 0);
      cycle("rdst", 1, 1, 1, 5, 0, 0, 0);
      check("rdst.pc", pc, 5);
      check("rdst.valid", id_valid, 0);
      check("rdst.flags", {isRtype, isItype, isJtype}, 0);
      cycle("rdf", 1, 0, 0, 0, 0, 0, 0);
      check("rdf.id_pc", id_pc, 5);
      check("rdf.valid", id_valid, 1);

      // PC wrap.
      cycle("w14", 1, 0, 1, 14, 0, 0, 0);
      check("wrap.pc14", pc, 14);
      cycle("w15", 1, 0, 0, 0, 0, 0, 0);
      check("wrap.pc15", pc, 15);
      cycle("w0", 1, 0, 0, 0, 0, 0, 0);
      check("wrap.pc0", pc, 0);
      check("wrap.id15", id_pc, 15);
      cycle("w1", 1, 0, 0, 0, 0, 0, 0);
      check("wrap.pc1", pc, 1);
      check("wrap.id0", id_pc, 0);

      // Same-edge write to the address being fetched.
      wa_old = m_mem[1];
      cycle("rbw", 1, 0, 0, 0, 1, 1, 32'h3C01BEEF);
      check("rbw.old", instruction, wa_old);
      cycle("rbw.rd", 1, 0, 1, 1, 0, 0, 0);
      cycle("rbw.new", 1, 0, 0, 0, 0, 0, 0);
      check("rbw.new", instruction, 32'h3C01BEEF);

      // Randomised traffic.
      for (int i = 0; i < 300; i++) begin
         cycle("rand", $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 15),
               $urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom);
      end

      // Asynchronous reset mid-run.
      cycle("pre", 1, 0, 0, 0, 0, 0, 0);
      #3 reset = 1'b1;
      #1;
      model_reset();
      check_all("arst");
      @(negedge clock);
      #2 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle("hold", 0, 0, 0, 0, 0, 0, 0);
         check("hold.pc", pc, 0);
      end
      cycle("restart", 1, 0, 0, 0, 0, 0, 0);
      check("restart.id_pc", id_pc, 0);
      check("restart.cnt", fetch_count, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
